// File: rtl/cartridge_bus_pkg.sv
// Shared types and constants for the cartridge bus engine: FSM state encoding,
// chip-select decode and default strobe timing.
package cartridge_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RESP
    } state_t;

    localparam logic [15:0] CS_BASE = 16'hA000;
    localparam logic [2:0]  CS_MASK = CS_BASE[15:13];

    localparam int unsigned DEF_SETUP_CYCLES  = 2;
    localparam int unsigned DEF_STROBE_CYCLES = 4;
    localparam int unsigned DEF_HOLD_CYCLES   = 1;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // External RAM window A000-BFFF is the only region that takes nCS
    function automatic logic cs_hit(input logic [15:0] addr);
        return (addr[15:13] == CS_MASK);
    endfunction

endpackage

// File: rtl/cartridge_bus_timer.sv
// Loadable down-counter; o_done_c is high while the count is zero, so a load
// of N-1 gives a phase exactly N cycles long.
module cartridge_bus_timer #(
    parameter int unsigned CNT_WIDTH = 3
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_load,
    input  logic [CNT_WIDTH-1:0] i_load_val,
    output logic                 o_done_c
);

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_WIDTH'(1);
        end
    end

    assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/cartridge_bus_engine.sv
// Game Boy cartridge bus cycle sequencer (setup/strobe/hold, read responses).
// Define CART_BURST_EN to honour req_len as an auto-incrementing burst.
module cartridge_bus_engine
    import cartridge_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned LEN_WIDTH     = 8,
    parameter int unsigned SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int unsigned STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    input  logic                  cart_rst,
    output logic [ADDR_WIDTH-1:0] pad_a_o,
    output logic [DATA_WIDTH-1:0] pad_d_o,
    input  logic [DATA_WIDTH-1:0] pad_d_i,
    output logic                  pad_d_t,
    output logic                  pad_nwr,
    output logic                  pad_nrd,
    output logic                  pad_ncs,
    output logic                  pad_nrst
);

    localparam int unsigned TMR_W = $clog2(max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES) + 1);
    localparam logic [TMR_W-1:0] SETUP_LD  = TMR_W'(SETUP_CYCLES - 1);
    localparam logic [TMR_W-1:0] STROBE_LD = TMR_W'(STROBE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(HOLD_CYCLES - 1);

    state_t                r_state, w_state_nxt;
    logic                  r_write, w_write_nxt;
    logic [ADDR_WIDTH-1:0] r_addr,  w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
    logic                  r_req_ready, r_rsp_valid, r_busy;
    logic                  r_d_t, r_nwr, r_nrd, r_ncs, r_nrst;
    logic                  w_busy_nxt, w_active_nxt;
    logic                  w_d_t_nxt, w_nwr_nxt, w_nrd_nxt, w_ncs_nxt;
    logic                  w_next_beat, w_last;
    logic                  w_load;
    logic [TMR_W-1:0]      w_load_val;
    logic                  w_tmr_done;

`ifdef CART_BURST_EN
    logic [LEN_WIDTH-1:0]  r_len,  w_len_nxt;
    logic [LEN_WIDTH-1:0]  r_beat, w_beat_nxt;
    assign w_last = (r_beat == r_len);
`else
    logic                  w_unused_len;
    assign w_unused_len = ^req_len;
    assign w_last       = 1'b1;
`endif

    cartridge_bus_timer #(
        .CNT_WIDTH (TMR_W)
    ) u_timer (
        .i_clock    (clock),
        .i_reset_n  (reset_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done_c   (w_tmr_done)
    );

    // State, transaction context and registered pad/handshake outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_d_t       <= 1'b1;
            r_nwr       <= 1'b1;
            r_nrd       <= 1'b1;
            r_ncs       <= 1'b1;
            r_nrst      <= 1'b1;
`ifdef CART_BURST_EN
            r_len       <= '0;
            r_beat      <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_write     <= w_write_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
            r_req_ready <= ~w_busy_nxt;
            r_rsp_valid <= (w_state_nxt == ST_RESP);
            r_busy      <= w_busy_nxt;
            r_d_t       <= w_d_t_nxt;
            r_nwr       <= w_nwr_nxt;
            r_nrd       <= w_nrd_nxt;
            r_ncs       <= w_ncs_nxt;
            r_nrst      <= ~cart_rst;
`ifdef CART_BURST_EN
            r_len       <= w_len_nxt;
            r_beat      <= w_beat_nxt;
`endif
        end
    end

    // Next state, phase timer loads and next pad values
    always_comb begin
        w_state_nxt = r_state;
        w_write_nxt = r_write;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_rdata;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_next_beat = 1'b0;
`ifdef CART_BURST_EN
        w_len_nxt   = r_len;
        w_beat_nxt  = r_beat;
`endif

        case (r_state)
            ST_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_write_nxt = req_write;
                    w_addr_nxt  = req_addr;
                    w_wdata_nxt = req_wdata;
`ifdef CART_BURST_EN
                    w_len_nxt   = req_len;
                    w_beat_nxt  = '0;
`endif
                    w_state_nxt = ST_SETUP;
                    w_load      = 1'b1;
                    w_load_val  = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_STROBE;
                    w_load      = 1'b1;
                    w_load_val  = STROBE_LD;
                end
            end
            ST_STROBE: begin
                if (w_tmr_done) begin
                    if (!r_write) begin
                        w_rdata_nxt = pad_d_i;
                    end
                    w_state_nxt = ST_HOLD;
                    w_load      = 1'b1;
                    w_load_val  = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (w_tmr_done) begin
                    if (r_write) begin
                        w_next_beat = 1'b1;
                    end else begin
                        w_state_nxt = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                // Response backpressure stalls the bus here
                if (rsp_ready) begin
                    w_next_beat = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_next_beat) begin
            if (w_last) begin
                w_state_nxt = ST_IDLE;
            end else begin
                w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
`ifdef CART_BURST_EN
                w_beat_nxt  = r_beat + LEN_WIDTH'(1);
`endif
                w_state_nxt = ST_SETUP;
                w_load      = 1'b1;
                w_load_val  = SETUP_LD;
            end
        end

        w_busy_nxt   = (w_state_nxt != ST_IDLE);
        w_active_nxt = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_STROBE) ||
                       (w_state_nxt == ST_HOLD);
        w_d_t_nxt    = ~(w_active_nxt && w_write_nxt);
        w_nrd_nxt    = ~((w_state_nxt == ST_STROBE) && !w_write_nxt);
        w_nwr_nxt    = ~((w_state_nxt == ST_STROBE) && w_write_nxt);
        w_ncs_nxt    = ~(w_busy_nxt && cs_hit(16'(w_addr_nxt)));
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign busy      = r_busy;
    assign pad_a_o   = r_addr;
    assign pad_d_o   = r_wdata;
    assign pad_d_t   = r_d_t;
    assign pad_nwr   = r_nwr;
    assign pad_nrd   = r_nrd;
    assign pad_ncs   = r_ncs;
    assign pad_nrst  = r_nrst;

endmodule

// File: tb/tb_cartridge_bus_engine.sv
// Scoreboard bench for cartridge_bus_engine: a pad model answers reads, a
// negedge monitor checks every strobe and every read response against queues.
module tb_cartridge_bus_engine;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic [7:0]  req_len = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [7:0]  rsp_rdata;
    logic        busy;
    logic        cart_rst = 1'b0;
    logic [15:0] pad_a_o;
    logic [7:0]  pad_d_o;
    logic [7:0]  pad_d_i;
    logic        pad_d_t;
    logic        pad_nwr;
    logic        pad_nrd;
    logic        pad_ncs;
    logic        pad_nrst;

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [7:0]  data;
        logic        ncs;
    } strobe_t;

    strobe_t     q_strobe[$];
    logic [7:0]  q_rdata[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clock = ~clock;

    cartridge_bus_engine dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .cart_rst  (cart_rst),
        .pad_a_o   (pad_a_o),
        .pad_d_o   (pad_d_o),
        .pad_d_i   (pad_d_i),
        .pad_d_t   (pad_d_t),
        .pad_nwr   (pad_nwr),
        .pad_nrd   (pad_nrd),
        .pad_ncs   (pad_ncs),
        .pad_nrst  (pad_nrst)
    );

    function automatic logic [7:0] cart_model(input logic [15:0] a);
        if (a == 16'h0147) return 8'h1B;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign pad_d_i = pad_nrd ? 8'h00 : cart_model(pad_a_o);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send_req(input logic w, input logic [15:0] a, input logic [7:0] d,
                            input logic [7:0] len, input bit push);
        int          nb;
        bit          ok;
        logic [15:0] ba;
        strobe_t     s;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("req_ready_timeout", 32'(0), 32'(1));
            return;
        end
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_len   = len;
        if (push) begin
`ifdef CART_BURST_EN
            nb = int'(len) + 1;
`else
            nb = 1;
`endif
            for (int b = 0; b < nb; b++) begin
                ba     = a + 16'(b);
                s.addr = ba;
                s.wr   = w;
                s.data = d;
                s.ncs  = (ba[15:13] == 3'b101) ? 1'b0 : 1'b1;
                q_strobe.push_back(s);
                if (!w) q_rdata.push_back(cart_model(ba));
            end
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (!busy && q_strobe.size() == 0 && q_rdata.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 32'(0), 32'(1));
    endtask

    // Strobe and response monitor
    initial begin
        int      rd_run;
        int      wr_run;
        strobe_t cur;
        strobe_t e;
        rd_run = 0;
        wr_run = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                rd_run = 0;
                wr_run = 0;
            end else begin
                if (!pad_nrd || !pad_nwr) begin
                    if (rd_run == 0 && wr_run == 0) begin
                        cur.addr = pad_a_o;
                        cur.wr   = ~pad_nwr;
                        cur.data = pad_d_o;
                        cur.ncs  = pad_ncs;
                    end
                    if (!pad_nrd) rd_run++;
                    if (!pad_nwr) wr_run++;
                end else if (rd_run != 0 || wr_run != 0) begin
                    if (q_strobe.size() == 0) begin
                        chk("strobe_unexpected", 32'(1), 32'(0));
                    end else begin
                        e = q_strobe.pop_front();
                        chk("strobe_addr", 32'(cur.addr), 32'(e.addr));
                        chk("strobe_kind", 32'(cur.wr), 32'(e.wr));
                        chk("strobe_ncs", 32'(cur.ncs), 32'(e.ncs));
                        chk("strobe_len", 32'(rd_run + wr_run), 32'(4));
                        if (e.wr) chk("strobe_wdata", 32'(cur.data), 32'(e.data));
                    end
                    rd_run = 0;
                    wr_run = 0;
                end
                if (rsp_valid && rsp_ready) begin
                    if (q_rdata.size() == 0) chk("rsp_unexpected", 32'(1), 32'(0));
                    else chk("rsp_rdata", 32'(rsp_rdata), 32'(q_rdata.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [7:0] held;
        bit         ok;

        repeat (4) @(posedge clock);
        @(negedge clock);
        chk("rst_req_ready", 32'(req_ready), 32'(1));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_pad_a", 32'(pad_a_o), 32'(0));
        chk("rst_pad_d", 32'(pad_d_o), 32'(0));
        chk("rst_pad_d_t", 32'(pad_d_t), 32'(1));
        chk("rst_strobes", 32'({pad_nwr, pad_nrd, pad_ncs, pad_nrst}), 32'(4'hF));
        reset_n = 1'b1;

        // Single read of the cartridge header byte
        send_req(1'b0, 16'h0147, 8'h00, 8'h00, 1'b1);
        wait_done();

        // Single write into the RAM window, phase-by-phase pad pattern
        send_req(1'b1, 16'hA000, 8'h0A, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("wr_d_t", 32'(pad_d_t), 32'((i < 7) ? 1 : 0) ^ 32'(1));
            chk("wr_nwr", 32'(pad_nwr), 32'((i >= 2 && i < 6) ? 0 : 1));
            chk("wr_ncs", 32'(pad_ncs), 32'((i < 7) ? 0 : 1));
            if (i < 7) chk("wr_pad_d", 32'(pad_d_o), 32'(8'h0A));
        end
        wait_done();

        // Bursts crossing a bank boundary, wrapping, and leaving the RAM window
        send_req(1'b0, 16'h3FFE, 8'h00, 8'd3, 1'b1);
        wait_done();
        send_req(1'b0, 16'hFFFF, 8'h00, 8'd1, 1'b1);
        wait_done();
        send_req(1'b0, 16'hBFFF, 8'h00, 8'd1, 1'b1);
        wait_done();
        send_req(1'b1, 16'hA0FE, 8'hC3, 8'd2, 1'b1);
        wait_done();

        // Response backpressure holds data and stalls the next beat
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        send_req(1'b0, 16'h0100, 8'h00, 8'd1, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp_rsp_seen", 32'(ok), 32'(1));
        held = cart_model(16'h0100);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clock);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'(1));
            chk("bp_rsp_rdata", 32'(rsp_rdata), 32'(held));
            chk("bp_nrd_idle", 32'(pad_nrd), 32'(1));
        end
        @(posedge clock);
        #1;
        rsp_ready = 1'b1;
        wait_done();

        // Reset during the write strobe aborts immediately
        send_req(1'b1, 16'h1234, 8'h55, 8'h00, 1'b0);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        chk("abort_pre_nwr", 32'(pad_nwr), 32'(0));
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("abort_nwr", 32'(pad_nwr), 32'(1));
        chk("abort_d_t", 32'(pad_d_t), 32'(1));
        chk("abort_req_ready", 32'(req_ready), 32'(1));
        chk("abort_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Cartridge reset is a plain registered level; traffic still runs
        cart_rst = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("nrst_low", 32'(pad_nrst), 32'(0));
        send_req(1'b0, 16'h4000, 8'h00, 8'h00, 1'b1);
        wait_done();
        @(posedge clock);
        #1;
        cart_rst = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("nrst_high", 32'(pad_nrst), 32'(1));

        // Random mix of reads and writes
        for (int i = 0; i < 8; i++) begin
            send_req(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                     8'($urandom_range(0, 3)), 1'b1);
            wait_done();
        end

        chk("q_strobe_empty", 32'(q_strobe.size()), 32'(0));
        chk("q_rdata_empty", 32'(q_rdata.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
